// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter
// Description : Shares one combinational ROM between an instruction-fetch port
//               (0) and a data/table port (1). Registered address, 2-cycle
//               request-to-ack latency. Define ROM_ARB_RR_EN for round-robin
//               tie-breaking; otherwise port 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          gnt1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]    state_q,    state_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] rdata0_q,   rdata0_d;
  logic [DW-1:0] rdata1_q,   rdata1_d;
  logic          ack0_q,     ack0_d;
  logic          ack1_q,     ack1_d;
  logic          busy_q,     busy_d;
  logic          gnt1_q,     gnt1_d;
  logic          win1;
  logic          grant;

  assign grant = (state_q == S_IDLE) && (req0 || req1);

`ifdef ROM_ARB_RR_EN
  // prio1_q high means port 1 wins the next tie
  logic prio1_q, prio1_d;

  assign win1 = req1 && (!req0 || prio1_q);

  always_comb begin
    prio1_d = prio1_q;
    if (grant) prio1_d = !win1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio1_q <= 1'b0;
    else        prio1_q <= prio1_d;
  end
`else
  assign win1 = req1 && !req0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req0 || req1) state_d = S_READ;
      S_READ:  state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    gnt1_d     = gnt1_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);
    if (grant) begin
      rom_addr_d = win1 ? addr1 : addr0;
      gnt1_d     = win1;
    end
    if (state_q == S_READ) begin
      if (gnt1_q) begin
        rdata1_d = rom_data;
        ack1_d   = 1'b1;
      end else begin
        rdata0_d = rom_data;
        ack0_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      gnt1_q     <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
      gnt1_q     <= gnt1_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign gnt1     = gnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_arbiter
// Description : Directed bench for rom_arbiter with a small ROM image model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [11:0] addr0, addr1;
  logic        ack0, ack1, busy, gnt1;
  logic [7:0]  rdata0, rdata1;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;

  int n_cmp;
  int n_bad;

  rom_arbiter #(.AW(12), .DW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .addr0    (addr0),
    .ack0     (ack0),
    .rdata0   (rdata0),
    .req1     (req1),
    .addr1    (addr1),
    .ack1     (ack1),
    .rdata1   (rdata1),
    .busy     (busy),
    .gnt1     (gnt1),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM image contents used by the test
  always_comb begin
    case (rom_addr)
      12'h000: rom_data = 8'hDE;
      12'h001: rom_data = 8'hAD;
      12'h002: rom_data = 8'hBE;
      12'h003: rom_data = 8'hEF;
      12'h004: rom_data = 8'h19;
      12'h005: rom_data = 8'h19;
      12'h7FF: rom_data = 8'hFF;
      default: rom_data = rom_addr[7:0] ^ 8'hA5;
    endcase
  end

  typedef struct {
    logic       r0;
    logic [11:0] a0;
    logic       r1;
    logic [11:0] a1;
    logic       g1;
    logic [7:0] d0;
    logic [7:0] d1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [11:0] ea,
                                  input logic [7:0] ed0, input logic [7:0] ed1);
    chk({tag, " rom_addr"}, 32'(rom_addr), 32'(ea));
    chk({tag, " rdata0"},   32'(rdata0),   32'(ed0));
    chk({tag, " rdata1"},   32'(rdata1),   32'(ed1));
    chk({tag, " ack0"},     32'(ack0),     32'd0);
    chk({tag, " ack1"},     32'(ack1),     32'd0);
    chk({tag, " busy"},     32'(busy),     32'd0);
    chk({tag, " gnt1"},     32'(gnt1),     32'd0);
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset", 12'h000, 8'h00, 8'h00);
    rst_n = 1'b1;
  endtask

  // Inputs already applied in IDLE; walks E0..E2 and checks each phase.
  task automatic txn(input string tag, input logic g, input logic [11:0] ea,
                     input logic [7:0] ed0, input logic [7:0] ed1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " E0 busy"},     32'(busy),     32'd1);
    chk({tag, " E0 gnt1"},     32'(gnt1),     32'(g));
    chk({tag, " E0 rom_addr"}, 32'(rom_addr), 32'(ea));
    chk({tag, " E0 ack"},      32'({ack1, ack0}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " E1 ack0"},   32'(ack0),   32'(!g));
    chk({tag, " E1 ack1"},   32'(ack1),   32'(g));
    chk({tag, " E1 rdata0"}, 32'(rdata0), 32'(ed0));
    chk({tag, " E1 rdata1"}, 32'(rdata1), 32'(ed1));
    chk({tag, " E1 busy"},   32'(busy),   32'd1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " E2 ack"},  32'({ack1, ack0}), 32'd0);
    chk({tag, " E2 busy"}, 32'(busy),         32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ed0, ed1;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;

    vecs[0] = '{1'b1, 12'h000, 1'b0, 12'h000, 1'b0, 8'hDE, 8'h00};
    vecs[1] = '{1'b0, 12'h000, 1'b1, 12'h003, 1'b1, 8'hDE, 8'hEF};
    vecs[2] = '{1'b0, 12'h000, 1'b1, 12'h7FF, 1'b1, 8'hDE, 8'hFF};
    vecs[3] = '{1'b1, 12'h001, 1'b1, 12'h002, 1'b0, 8'hAD, 8'hFF};
`ifdef ROM_ARB_RR_EN
    vecs[4] = '{1'b1, 12'h001, 1'b1, 12'h002, 1'b1, 8'hAD, 8'hBE};
    vecs[5] = '{1'b1, 12'h004, 1'b0, 12'h000, 1'b0, 8'h19, 8'hBE};
`else
    vecs[4] = '{1'b1, 12'h001, 1'b1, 12'h002, 1'b0, 8'hAD, 8'hFF};
    vecs[5] = '{1'b1, 12'h004, 1'b0, 12'h000, 1'b0, 8'h19, 8'hFF};
`endif

    do_reset();

    for (int i = 0; i < 6; i++) begin
      req0 = vecs[i].r0; addr0 = vecs[i].a0;
      req1 = vecs[i].r1; addr1 = vecs[i].a1;
      txn($sformatf("vec%0d", i), vecs[i].g1,
          vecs[i].g1 ? vecs[i].a1 : vecs[i].a0, vecs[i].d0, vecs[i].d1);
      req0 = 1'b0; req1 = 1'b0;
    end
    ed1 = vecs[5].d1;

    // req0 held through ACK, address changed after E2: next grant at E3
    req0 = 1'b1; addr0 = 12'h000;
    txn("hold0 first", 1'b0, 12'h000, 8'hDE, ed1);
    chk("hold0 rom_addr kept", 32'(rom_addr), 32'h000);
    addr0 = 12'h004;
    txn("hold0 second", 1'b0, 12'h004, 8'h19, ed1);
    req0 = 1'b0;

    // Both ports requesting continuously from a fresh reset
    do_reset();
    req0 = 1'b1; addr0 = 12'h001;
    req1 = 1'b1; addr1 = 12'h002;
    ed0 = 8'h00; ed1 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      logic g;
`ifdef ROM_ARB_RR_EN
      g = (i % 2) == 1;
`else
      g = 1'b0;
`endif
      if (g) ed1 = 8'hBE;
      else   ed0 = 8'hAD;
      txn($sformatf("both%0d", i), g, g ? 12'h002 : 12'h001, ed0, ed1);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset asserted mid-READ drops the transaction
    do_reset();
    req0 = 1'b1; addr0 = 12'h003;
    @(posedge clk);
    @(negedge clk);
    chk("midrst busy before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst async", 12'h000, 8'h00, 8'h00);
    req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("midrst no ack %0d", i), 32'({ack1, ack0, busy}), 32'd0);
    end
    req0 = 1'b1; addr0 = 12'h005;
    txn("after rst", 1'b0, 12'h005, 8'h19, 8'h00);
    req0 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
